// File: rtl/mdu_sequencer_pkg.sv
// Shared types for the execute-stage multiply/divide sequencer.
// Latency: none (types, constants and pure decode functions only).
// Backpressure: not applicable.
package mdu_sequencer_pkg;

    localparam int MDU_XLEN = 64;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    // Per-op control bits derived once at accept time.
    typedef struct packed {
        logic signA;
        logic signB;
        logic isDiv;
        logic isRem;
    } opInfo_t;

    // Word variants only exist for MUL/DIV/DIVU/REM/REMU; a stray high-half
    // word multiply is executed as MULW so the sequencer never wedges.
    function automatic mdu_op_t effectiveOp(input logic [2:0] funct3, input logic word);
        mdu_op_t op;
        op = mdu_op_t'(funct3);
        if (word && (op == OP_MULH || op == OP_MULHSU || op == OP_MULHU)) begin
            op = OP_MUL;
        end
        return op;
    endfunction

    function automatic opInfo_t decodeOp(input mdu_op_t op);
        opInfo_t info;
        info = '0;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                info.signA = 1'b1;
                info.signB = 1'b1;
            end
            OP_MULHSU: info.signA = 1'b1;
            default: ;
        endcase
        info.isDiv = op[2];
        info.isRem = op[2] & op[1];
        return info;
    endfunction

endpackage

// File: rtl/mdu_sequencer_negate.sv
// Conditional two's-complement: dout = neg ? -din : din.
// Latency: purely combinational.
// Backpressure: none, no state.
module mdu_negate
    import mdu_sequencer_pkg::*;
#(
    parameter int W = 2 * MDU_XLEN
) (
    input  logic         neg,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RV64M multiply (shift-add) / divide (restoring) beside the ALU.
// Latency: N+1 cycles from accept to done_o (N = XLEN or XLEN/2), 1 cycle for div-by-zero/overflow.
// Backpressure: result held in DONE until ready_i; stall_o holds the pipe while an op is outstanding.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int XLEN  = MDU_XLEN,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic [2:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    input  logic            ready_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int HALF = XLEN / 2;

    function automatic logic [XLEN-1:0] sextWord(input logic [HALF-1:0] v);
        return {{HALF{v[HALF-1]}}, v};
    endfunction

    mdu_state_t       state, stateNext;
    logic [CNT_W-1:0] count, countNext;
    logic             loadOps, loadSpecial, finish;

    // Latched operation context and iteration registers.
    mdu_op_t          opReg;
    logic             wordReg;
    logic             negA, negB;
    logic [2*XLEN-1:0] acc, mcand;
    logic [XLEN-1:0]  mplier;
    logic [XLEN-1:0]  rem, quo, divisor;
    logic [XLEN-1:0]  resultReg;

    // ---------------- accept-time operand preparation ----------------
    mdu_op_t         opIn;
    opInfo_t         infoIn;
    logic [XLEN-1:0] aAdj, bAdj, aMag, bMag;
    logic            aNeg, bNeg;
    logic            divByZero, divOverflow, special;
    logic [XLEN-1:0] mostNeg, specialRaw, specialRes;

    assign opIn   = effectiveOp(op_i, word_i);
    assign infoIn = decodeOp(opIn);

    // Width-adjust operands: word ops see only the low half, extended per signedness.
    always_comb begin
        aAdj = a_i;
        bAdj = b_i;
        if (word_i) begin
            aAdj = infoIn.signA ? sextWord(a_i[HALF-1:0]) : {{HALF{1'b0}}, a_i[HALF-1:0]};
            bAdj = infoIn.signB ? sextWord(b_i[HALF-1:0]) : {{HALF{1'b0}}, b_i[HALF-1:0]};
        end
    end

    assign aNeg = infoIn.signA & aAdj[XLEN-1];
    assign bNeg = infoIn.signB & bAdj[XLEN-1];

    mdu_negate #(.W(XLEN)) uNegA (.neg(aNeg), .din(aAdj), .dout(aMag));
    mdu_negate #(.W(XLEN)) uNegB (.neg(bNeg), .din(bAdj), .dout(bMag));

    assign mostNeg     = word_i ? {{(HALF + 1){1'b1}}, {(HALF - 1){1'b0}}}
                                : {1'b1, {(XLEN - 1){1'b0}}};
    assign divByZero   = infoIn.isDiv & (bAdj == '0);
    assign divOverflow = infoIn.isDiv & infoIn.signA & (aAdj == mostNeg) & (bAdj == '1);
    assign special     = divByZero | divOverflow;

    // Fast-path answers: x/0 -> all ones rem x; MIN/-1 -> MIN rem 0.
    always_comb begin
        if (infoIn.isRem) begin
            specialRaw = divByZero ? aAdj : '0;
        end else begin
            specialRaw = divByZero ? '1 : aAdj;
        end
        specialRes = word_i ? sextWord(specialRaw[HALF-1:0]) : specialRaw;
    end

    // ---------------- iteration datapath ----------------
    logic [2*XLEN-1:0] accNext, prodC;
    logic [XLEN:0]     remShift, trial;
    logic              qBit;
    logic [XLEN-1:0]   remNext, quoNext, quoC, remC;
    logic [XLEN-1:0]   iterRaw, iterRes;

    assign accNext  = acc + (mplier[0] ? mcand : '0);
    assign remShift = {rem, quo[XLEN-1]};
    assign trial    = remShift - {1'b0, divisor};
    assign qBit     = ~trial[XLEN];
    assign remNext  = qBit ? trial[XLEN-1:0] : remShift[XLEN-1:0];
    assign quoNext  = {quo[XLEN-2:0], qBit};

    mdu_negate #(.W(2*XLEN)) uNegProd (.neg(negA ^ negB), .din(accNext), .dout(prodC));
    mdu_negate #(.W(XLEN))   uNegQuo  (.neg(negA ^ negB), .din(quoNext), .dout(quoC));
    mdu_negate #(.W(XLEN))   uNegRem  (.neg(negA),        .din(remNext), .dout(remC));

    // Pick the architectural result from the final-step values.
    always_comb begin
        case (opReg)
            OP_MUL:                      iterRaw = prodC[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: iterRaw = prodC[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             iterRaw = quoC;
            default:                     iterRaw = remC;
        endcase
        iterRes = wordReg ? sextWord(iterRaw[HALF-1:0]) : iterRaw;
    end

    // ---------------- control FSM ----------------
    // State and iteration counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
        end
    end

    // Next-state and datapath enables; flush overrides everything.
    always_comb begin
        stateNext   = state;
        countNext   = count;
        loadOps     = 1'b0;
        loadSpecial = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                if (valid_i) begin
                    if (special) begin
                        stateNext   = DONE;
                        loadSpecial = 1'b1;
                    end else begin
                        stateNext = infoIn.isDiv ? DIV : MUL;
                        countNext = word_i ? CNT_W'(HALF) : CNT_W'(XLEN);
                        loadOps   = 1'b1;
                    end
                end
            end
            MUL, DIV: begin
                countNext = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    stateNext = DONE;
                    finish    = 1'b1;
                end
            end
            DONE: begin
                if (ready_i) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
        if (flush_i) begin
            stateNext   = IDLE;
            countNext   = '0;
            loadOps     = 1'b0;
            loadSpecial = 1'b0;
            finish      = 1'b0;
        end
    end

    // Operand latch, per-cycle shift-add / restoring step, and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            opReg     <= OP_MUL;
            wordReg   <= 1'b0;
            negA      <= 1'b0;
            negB      <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem       <= '0;
            quo       <= '0;
            divisor   <= '0;
            resultReg <= '0;
        end else begin
            if (loadOps) begin
                opReg   <= opIn;
                wordReg <= word_i;
                negA    <= aNeg;
                negB    <= bNeg;
                acc     <= '0;
                mcand   <= {{XLEN{1'b0}}, aMag};
                mplier  <= bMag;
                rem     <= '0;
                // Word dividends sit in the top half so N steps consume them.
                quo     <= word_i ? (aMag << HALF) : aMag;
                divisor <= bMag;
            end else if (state == MUL) begin
                acc    <= accNext;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end else if (state == DIV) begin
                rem <= remNext;
                quo <= quoNext;
            end
            if (loadSpecial) begin
                resultReg <= specialRes;
            end else if (finish) begin
                resultReg <= iterRes;
            end
        end
    end

    assign done_o   = (state == DONE);
    assign result_o = resultReg;
    assign stall_o  = valid_i & ~(done_o & ready_i);

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: arithmetic results, latency, flush/reset and backpressure.
// Latency: checks N+1 cycle ops and 1-cycle fast paths.
// Backpressure: exercises ready_i low in DONE.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic [2:0]  op_i;
    logic        word_i;
    logic [63:0] a_i, b_i;
    logic        flush_i;
    logic        ready_i;
    logic        stall_o;
    logic        done_o;
    logic [63:0] result_o;

    int total = 0;
    int bad   = 0;

    mdu_sequencer dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .op_i(op_i), .word_i(word_i),
        .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .ready_i(ready_i),
        .stall_o(stall_o), .done_o(done_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge (input-drive point).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present an op and wait for done_o; returns at the falling edge of the done cycle.
    task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic rdy,
                         output int lat, output int stalls, output logic [63:0] res);
        valid_i = 1'b1; op_i = op; word_i = w; a_i = a; b_i = b; ready_i = rdy;
        lat = -1; stalls = 0; res = 'x;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done_o) begin
                lat = k;
                res = result_o;
                break;
            end
            if (stall_o) stalls++;
            cyc();
        end
    endtask

    // Retire the completed op and return to an idle drive point.
    task automatic retire();
        cyc();
        valid_i = 1'b0;
        ready_i = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
        op_i = 3'd0; word_i = 1'b0; a_i = '0; b_i = '0;
        cyc(); cyc();
        @(negedge clk);
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done_o); end
        total++; if (result_o !== 64'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", result_o); end
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall_o); end
        valid_i = 1'b1;
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL reset_stall_valid got=%0b exp=1", stall_o); end
        valid_i = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_mul();
        int lat, st; logic [63:0] r;
        issue(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, lat, st, r);
        total++; if (lat !== 65) begin bad++; $display("FAIL mul_latency got=%0d exp=65", lat); end
        total++; if (st !== 65) begin bad++; $display("FAIL mul_stall_cycles got=%0d exp=65", st); end
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFF1) begin bad++; $display("FAIL mul_result got=%h exp=fffffffffffffff1", r); end
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL mul_stall_release got=%0b exp=0", stall_o); end
        retire();
        @(negedge clk);
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL mul_back_to_idle got=%0b exp=0", done_o); end
        cyc();
        issue(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, lat, st, r);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL mulhu got=%h exp=fffffffffffffffe", r); end
        retire();
        issue(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, lat, st, r);
        total++; if (r !== 64'd0) begin bad++; $display("FAIL mulh got=%h exp=0", r); end
        retire();
        issue(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, lat, st, r);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL mulhsu got=%h exp=ffffffffffffffff", r); end
        retire();
    endtask

    task automatic test_special();
        int lat, st; logic [63:0] r;
        issue(3'd4, 1'b0, 64'd7, 64'd0, 1'b1, lat, st, r);
        total++; if (lat !== 1) begin bad++; $display("FAIL div0_latency got=%0d exp=1", lat); end
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL div0_quot got=%h exp=ffffffffffffffff", r); end
        retire();
        issue(3'd6, 1'b0, 64'd7, 64'd0, 1'b1, lat, st, r);
        total++; if (r !== 64'd7) begin bad++; $display("FAIL div0_rem got=%h exp=7", r); end
        retire();
        issue(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, lat, st, r);
        total++; if (lat !== 1) begin bad++; $display("FAIL ovf_latency got=%0d exp=1", lat); end
        total++; if (r !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL ovf_quot got=%h exp=8000000000000000", r); end
        retire();
        issue(3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, lat, st, r);
        total++; if (r !== 64'd0) begin bad++; $display("FAIL ovf_rem got=%h exp=0", r); end
        retire();
    endtask

    task automatic test_word();
        int lat, st; logic [63:0] r;
        issue(3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, lat, st, r);
        total++; if (lat !== 33) begin bad++; $display("FAIL divw_latency got=%0d exp=33", lat); end
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL divw got=%h exp=fffffffffffffffd", r); end
        retire();
        issue(3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, lat, st, r);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL remw got=%h exp=ffffffffffffffff", r); end
        retire();
        issue(3'd0, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 1'b1, lat, st, r);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL mulw got=%h exp=fffffffffffffffe", r); end
        retire();
    endtask

    task automatic test_flush();
        int lat, st, seen; logic [63:0] r;
        valid_i = 1'b1; op_i = 3'd4; word_i = 1'b0; a_i = 64'd100; b_i = 64'd7; ready_i = 1'b1;
        repeat (20) cyc();
        flush_i = 1'b1; valid_i = 1'b0;
        cyc();
        flush_i = 1'b0;
        @(negedge clk);
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL flush_done got=%0b exp=0", done_o); end
        cyc();
        issue(3'd0, 1'b0, 64'd6, 64'd7, 1'b1, lat, st, r);
        total++; if (lat !== 65) begin bad++; $display("FAIL flush_next_latency got=%0d exp=65", lat); end
        total++; if (r !== 64'd42) begin bad++; $display("FAIL flush_next_result got=%0d exp=42", r); end
        retire();
        // Flush in IDLE must suppress the accept entirely.
        valid_i = 1'b1; op_i = 3'd5; a_i = 64'd100; b_i = 64'd7; flush_i = 1'b1;
        cyc();
        valid_i = 1'b0; flush_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done_o) seen++;
            cyc();
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL flush_idle_done_cycles got=%0d exp=0", seen); end
    endtask

    task automatic test_reset_mid();
        int lat, st; logic [63:0] r;
        valid_i = 1'b1; op_i = 3'd0; word_i = 1'b0; a_i = 64'd5; b_i = 64'd5; ready_i = 1'b1;
        repeat (10) cyc();
        reset = 1'b1; valid_i = 1'b0;
        cyc();
        @(negedge clk);
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%0b exp=0", done_o); end
        total++; if (result_o !== 64'd0) begin bad++; $display("FAIL rstmid_result got=%h exp=0", result_o); end
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rstmid_stall got=%0b exp=0", stall_o); end
        cyc();
        reset = 1'b0;
        issue(3'd0, 1'b0, 64'd6, 64'd7, 1'b1, lat, st, r);
        total++; if (lat !== 65) begin bad++; $display("FAIL rstmid_next_latency got=%0d exp=65", lat); end
        total++; if (r !== 64'd42) begin bad++; $display("FAIL rstmid_next_result got=%0d exp=42", r); end
        retire();
    endtask

    task automatic test_back_to_back();
        int lat, st; logic [63:0] r;
        issue(3'd5, 1'b0, 64'd100, 64'd7, 1'b0, lat, st, r);
        total++; if (r !== 64'd14) begin bad++; $display("FAIL bp_result got=%0d exp=14", r); end
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL bp_stall_first got=%0b exp=1", stall_o); end
        for (int i = 1; i < 5; i++) begin
            cyc();
            @(negedge clk);
            total++; if (done_o !== 1'b1 || result_o !== 64'd14 || stall_o !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold_%0d done=%0b result=%0d stall=%0b exp done=1 result=14 stall=1",
                         i, done_o, result_o, stall_o);
            end
        end
        cyc();
        ready_i = 1'b1;
        @(negedge clk);
        total++; if (stall_o !== 1'b0 || done_o !== 1'b1) begin
            bad++; $display("FAIL bp_release stall=%0b done=%0b exp stall=0 done=1", stall_o, done_o);
        end
        cyc();
        issue(3'd7, 1'b0, 64'd100, 64'd7, 1'b1, lat, st, r);
        total++; if (lat !== 65) begin bad++; $display("FAIL b2b_latency got=%0d exp=65", lat); end
        total++; if (r !== 64'd2) begin bad++; $display("FAIL b2b_result got=%0d exp=2", r); end
        retire();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_special();
        test_word();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
